ps2_host_tx: RTL

- PS/2 host-to-device transmitter; the opposite direction of the keyboard receiver.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Drives the open-collector PS2_KBCLK/PS2_KBDAT lines through pull-low enables.
- The top level turns each enable into a tri-state low driver; the receiver keeps listening on the same pins.

---
 rtl/ps2_host_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/8 data/odd parity/stop
// on device-generated clock edges, then collects the device ACK through pull-low enables.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int CNT_W          = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   // state     | meaning
   // IDLE      | both lines released, waiting for tx_start
   // INHIBIT   | clock held low for INHIBIT_CYCLES
   // START     | clock and data low (start bit) for one cycle
   // SEND      | clock released, data/parity/stop shifted on device falling edges
   // ACK       | waiting for the device ACK edge
   // WAIT_IDLE | waiting for both lines high before reporting
   typedef enum logic [2:0] {
      IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE
   } state_t;

   localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d;
   logic [8:0]       shift_q, shift_d;
   logic             nack_q, nack_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             clk_s1_q, clk_s2_q, clk_s3_q;
   logic             dat_s1_q, dat_s2_q;
   logic             fall;

   assign fall = clk_s3_q & ~clk_s2_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      nack_d   = nack_q;
      clk_oe_d = clk_oe_q;
      dat_oe_d = dat_oe_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      case (state_q)
         IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            // the cycle carrying a done/error pulse may not accept a new byte
            if (tx_start && !done_q && !error_q) begin
               shift_d  = {~^tx_data, tx_data};
               cnt_d    = INH_LOAD;
               clk_oe_d = 1'b1;
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt_q == '0) begin
               dat_oe_d = 1'b1;
               state_d  = START;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         START: begin
            clk_oe_d = 1'b0;
            cnt_d    = TO_LOAD;
            bit_d    = 4'd0;
            nack_d   = 1'b0;
            state_d  = SEND;
         end
         SEND, ACK, WAIT_IDLE: begin
            if (fall) begin
               cnt_d = TO_LOAD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end
            if (!fall && cnt_q == '0) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error_d  = 1'b1;
               state_d  = IDLE;
            end else begin
               case (state_q)
                  SEND: begin
                     if (fall) begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd9) begin
                           dat_oe_d = 1'b0;
                           state_d  = ACK;
                        end else begin
                           dat_oe_d = ~shift_q[0];
                           shift_d  = {1'b0, shift_q[8:1]};
                        end
                     end
                  end
                  ACK: begin
                     if (fall) begin
                        nack_d  = dat_s2_q;
                        state_d = WAIT_IDLE;
                     end
                  end
                  default: begin
                     if (clk_s2_q && dat_s2_q) begin
                        done_d  = ~nack_q;
                        error_d = nack_q;
                        state_d = IDLE;
                     end
                  end
               endcase
            end
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         nack_q   <= 1'b0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         nack_q   <= nack_d;
         clk_oe_q <= clk_oe_d;
         dat_oe_q <= dat_oe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
         clk_s1_q <= ps2_clk_in;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= ps2_dat_in;
         dat_s2_q <= dat_s1_q;
      end
   end

   assign tx_busy    = busy_q;
   assign tx_done    = done_q;
   assign tx_error   = error_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;

endmodule
